dmem_wbuf_resp: RTL and testbench

DMEM_WBUF_RESP -- requirements
Module: dmem_wbuf_resp

---
 rtl/dmem_wbuf_resp.sv | 142 ++++++++++++++
 tb/tb_dmem_wbuf_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wbuf_resp.sv
// ---------------------------------------------------------------------------
// dmem_wbuf_resp
// Data memory behind a posted-write buffer. Stores enter a small FIFO with a
// one-cycle latency and drain into the RAM at most once every DRAIN_DIV
// cycles. Loads read the RAM combinationally.
//
// Optional feature, macro DMEM_WBUF_STORE_FWD_EN:
//   defined   - a load that hits buffered stores returns the newest match.
//   undefined - a load that hits any buffered store stalls until those
//               stores have drained; load data always comes from the RAM.
// ---------------------------------------------------------------------------
module dmem_wbuf_resp #(
  parameter int DEPTH_LOG2 = 6,  // RAM holds 2**DEPTH_LOG2 words
  parameter int WBUF_DEPTH = 4,  // buffer entries, power of two, >= 2
  parameter int DRAIN_DIV  = 2   // one drain at most every DRAIN_DIV cycles
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        wbuf_empty_o
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);

  // Storage
  logic [31:0]           r_mem      [WORDS];
  logic [DEPTH_LOG2-1:0] r_buf_idx  [WBUF_DEPTH];
  logic [31:0]           r_buf_data [WBUF_DEPTH];

  // Buffer control state
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_div;

  // Decoded request and control
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hit;
  logic [31:0]           w_ram_rdata;
`ifdef DMEM_WBUF_STORE_FWD_EN
  logic [31:0]           w_fwd_data;
`endif
  logic                  w_unused;

  // Byte-offset bits and address bits above the RAM size select nothing.
  assign w_idx    = addr_i[DEPTH_LOG2+1:2];
  assign w_unused = &{1'b0, memread_i, addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  assign w_full       = (r_count == FULL_CNT);
  assign wbuf_empty_o = (r_count == '0);

  // A full buffer refuses the store even if the head drains on this edge;
  // the store simply retries next cycle.
  assign w_push = memwrite_i && !stall_o;
  assign w_pop  = (r_div == DIV_LAST) && (r_count != '0);

  // Scan valid entries oldest to newest so the last hit is the newest store.
  // NOTE: every signal gets its default before the loop so no path through
  // this block leaves a value held, which would infer a latch.
  always_comb begin
    w_hit = 1'b0;
`ifdef DMEM_WBUF_STORE_FWD_EN
    w_fwd_data = '0;
`endif
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) &&
          (r_buf_idx[r_head + PTR_W'(k)] == w_idx)) begin
        w_hit = 1'b1;
`ifdef DMEM_WBUF_STORE_FWD_EN
        w_fwd_data = r_buf_data[r_head + PTR_W'(k)];
`endif
      end
    end
  end

  assign w_ram_rdata = r_mem[w_idx];

  // Load data and stall: forwarding build hides buffered stores, the
  // non-forwarding build holds a load until its stores reach the RAM.
  always_comb begin
`ifdef DMEM_WBUF_STORE_FWD_EN
    rdata_o = w_hit ? w_fwd_data : w_ram_rdata;
    stall_o = memwrite_i && w_full;
`else
    rdata_o = w_ram_rdata;
    stall_o = (memwrite_i && w_full) || (memread_i && w_hit);
`endif
  end

  // Pointers, occupancy and the free-running drain divider.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_div   <= '0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer entry payload at the tail; validity comes from head/count alone.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_idx[r_tail]  <= w_idx;
      r_buf_data[r_tail] <= wdata_i;
    end
  end

  // Drain the head entry into the RAM.
  // NOTE: the RAM and buffer payload arrays have no reset; clearing them would
  // cost a reset fan-out per bit and nothing depends on their initial value.
  always_ff @(posedge clk_i) begin
    if (w_pop && !reset_i) begin
      r_mem[r_buf_idx[r_head]] <= r_buf_data[r_head];
    end
  end

endmodule

// File: tb/tb_dmem_wbuf_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_wbuf_resp
// Two instances: u_dut (DRAIN_DIV=4) carries the directed sequence, u_dut1
// (DRAIN_DIV=1) the back-to-back store stream. Inputs change on the falling
// edge and outputs are sampled 1 ns later. Expected load data is pushed to a
// queue when the load is issued and popped when the load completes.
// Works with DMEM_WBUF_STORE_FWD_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_dmem_wbuf_resp;

  localparam int LIM = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_we, a_re, a_stall, a_empty;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_we, b_re, b_stall, b_empty;

  dmem_wbuf_resp #(.DEPTH_LOG2(6), .WBUF_DEPTH(4), .DRAIN_DIV(4)) u_dut (
    .clk_i(clk), .reset_i(rst), .addr_i(a_addr), .wdata_i(a_wdata),
    .memwrite_i(a_we), .memread_i(a_re), .rdata_o(a_rdata),
    .stall_o(a_stall), .wbuf_empty_o(a_empty)
  );

  dmem_wbuf_resp #(.DEPTH_LOG2(6), .WBUF_DEPTH(4), .DRAIN_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .addr_i(b_addr), .wdata_i(b_wdata),
    .memwrite_i(b_we), .memread_i(b_re), .rdata_o(b_rdata),
    .stall_o(b_stall), .wbuf_empty_o(b_empty)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] model [64];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic idle();
    @(negedge clk);
    a_we = 1'b0;
    a_re = 1'b0;
  endtask

  // Hold a store until it is accepted; report how many cycles it stalled.
  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       output int stalls);
    stalls = 0;
    @(negedge clk);
    a_addr = addr; a_wdata = data; a_we = 1'b1; a_re = 1'b0;
    #1;
    while (a_stall && stalls < LIM) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check("store_accept_in_time", {31'b0, stalls < LIM}, 32'd1);
    model[idx_of(addr)] = data;
  endtask

  // Issue a load, wait until it is no longer stalled, compare with scoreboard.
  task automatic load(input logic [31:0] addr, output int stalls);
    stalls = 0;
    exp_q.push_back(model[idx_of(addr)]);
    @(negedge clk);
    a_addr = addr; a_we = 1'b0; a_re = 1'b1;
    #1;
    while (a_stall && stalls < LIM) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check("load_done_in_time", {31'b0, stalls < LIM}, 32'd1);
    check($sformatf("load_data_%08h", addr), a_rdata, exp_q.pop_front());
  endtask

  task automatic wait_empty(output int cycles);
    cycles = 0;
    @(negedge clk);
    a_we = 1'b0;
    a_re = 1'b0;
    #1;
    while (!a_empty && cycles < LIM) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check("drain_in_time", {31'b0, cycles < LIM}, 32'd1);
  endtask

  // Leave the bench so that the next store task is captured on an edge where
  // the DRAIN_DIV=4 divider is at its last value with an empty buffer.
  task automatic align();
    int s, c;
    wait_empty(c);
    store(32'h0000_00FC, 32'h5A5A_5A5A, s);
    wait_empty(c);  // first empty sample follows a drain edge
    idle();
    idle();
  endtask

  initial begin
    int s, c;
    logic [31:0] old_v [3];

    rst = 1'b1;
    a_addr = '0; a_wdata = '0; a_we = 1'b1; a_re = 1'b0;
    b_addr = '0; b_wdata = '0; b_we = 1'b1; b_re = 1'b0;
    #12;
    check("rst_empty",       {31'b0, a_empty}, 32'd1);
    check("rst_stall",       {31'b0, a_stall}, 32'd0);
    check("rst_count",       32'(u_dut.r_count), 32'd0);
    check("rst_empty_div1",  {31'b0, b_empty}, 32'd1);
    check("rst_stall_div1",  {31'b0, b_stall}, 32'd0);
    a_we = 1'b0;
    b_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Store followed directly by a load of the same word.
    store(32'h0000_0010, 32'h1111_1111, s);
    load(32'h0000_0010, s);
`ifdef DMEM_WBUF_STORE_FWD_EN
    check("fwd_load_no_stall", 32'(s), 32'd0);
`else
    check("hazard_load_stalls", {31'b0, s > 0}, 32'd1);
`endif

    // Two stores to one word: newest wins, then RAM holds it after drain.
    store(32'h0000_0020, 32'h0000_000A, s);
    store(32'h0000_0020, 32'h0000_000B, s);
    load(32'h0000_0020, s);
    wait_empty(c);
    load(32'h0000_0020, s);
    check("ram_load_no_stall", 32'(s), 32'd0);

    // Load data does not depend on memread.
    @(negedge clk);
    a_addr = 32'h0000_0010; a_we = 1'b0; a_re = 1'b0;
    #1;
    check("rdata_without_memread", a_rdata, model[4]);

    // Upper address bits alias, byte offset ignored.
    store(32'h0000_0104, 32'h0000_CAFE, s);
    load(32'h0000_0004, s);
    wait_empty(c);
    load(32'h0000_0007, s);

    // Five back-to-back stores against a 4-deep buffer.
    align();
    for (int i = 0; i < 4; i++) begin
      store(32'h0000_0080 + 32'(i * 4), 32'hA000_0000 + 32'(i), s);
      check($sformatf("burst_store%0d_no_stall", i), 32'(s), 32'd0);
    end
    store(32'h0000_0090, 32'hA000_0004, s);
    check("fifth_store_one_stall", 32'(s), 32'd1);
    wait_empty(c);
    check("burst_drained_within_20", {31'b0, c <= 20}, 32'd1);
    for (int i = 0; i < 5; i++) load(32'h0000_0080 + 32'(i * 4), s);

    // Asynchronous reset with three buffered stores.
    for (int i = 0; i < 3; i++) store(32'h0000_0050 + 32'(i * 4), 32'h100 + 32'(i), s);
    for (int i = 0; i < 3; i++) old_v[i] = model[20 + i];
    align();
    for (int i = 0; i < 3; i++) store(32'h0000_0050 + 32'(i * 4), 32'h200 + 32'(i), s);
    @(posedge clk);
    #1;
    check("filled_to_three", 32'(u_dut.r_count), 32'd3);
    a_we = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(u_dut.r_count), 32'd0);
    check("async_rst_empty", {31'b0, a_empty}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model[20 + i] = old_v[i];
    for (int i = 0; i < 3; i++) load(32'h0000_0050 + 32'(i * 4), s);

    // DRAIN_DIV=1: a store every cycle never fills the buffer.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_addr = 32'h0000_00C0 + 32'(i * 4); b_wdata = 32'hD000_0000 + 32'(i);
      b_we = 1'b1; b_re = 1'b0;
      #1;
      check($sformatf("div1_no_stall_%0d", i), {31'b0, b_stall}, 32'd0);
      check($sformatf("div1_count_le1_%0d", i),
            {31'b0, u_dut1.r_count <= 3'd1}, 32'd1);
    end
    @(negedge clk);
    b_we = 1'b0;
    @(negedge clk);
    #1;
    check("div1_empty_after_stream", {31'b0, b_empty}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'hD000_0000 + 32'(i));
      @(negedge clk);
      b_addr = 32'h0000_00C0 + 32'(i * 4); b_re = 1'b1;
      #1;
      check($sformatf("div1_load_%0d", i), b_rdata, exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
